// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, error-code and config-register constants for ctrl_sequencer.
// Rev 1.0
`default_nettype none

package ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RDN_LD  = 3'd1;
  localparam state_t ST_DNN_LD  = 3'd2;
  localparam state_t ST_RDN_RUN = 3'd3;
  localparam state_t ST_DNN_RUN = 3'd4;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_BUSY       = 2'b01;
  localparam logic [1:0] ERR_NOT_LOADED = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

  localparam logic [1:0] REG_IMG = 2'd0;
  localparam logic [1:0] REG_RDN = 2'd1;
  localparam logic [1:0] REG_DNN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ctrl_watchdog.sv
// ctrl_watchdog: per-phase cycle counter; flags the last permitted cycle of a phase.
// Rev 1.0
`default_nettype none

module ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT so a stalled caller cannot wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = enable && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: config registers plus the load / process sequencing FSM with watchdog abort.
// Rev 1.0
`default_nettype none

module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int ADDR_W         = 28,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        reg_sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] reg_databus,
  input  logic              begin_rdn_load,
  input  logic              begin_dnn_load,
  input  logic              begin_proc,
  output logic              rdn_ld_start,
  output logic              dnn_ld_start,
  output logic [ADDR_W-1:0] ld_addr,
  input  logic              rdn_ld_done,
  input  logic              dnn_ld_done,
  output logic [ADDR_W-1:0] img_addr,
  output logic              rdn_start,
  input  logic              rdn_done,
  output logic              dnn_start,
  input  logic              dnn_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] reg_img;
  logic [ADDR_W-1:0] reg_rdn;
  logic [ADDR_W-1:0] reg_dnn;
  logic              rdn_loaded;
  logic              dnn_loaded;
  logic              any_begin;
  logic              phase_done;
  logic              abort;
  logic              wd_timeout;
  logic              wd_clear;
  logic              wd_enable;
  logic [ADDR_W-1:0] img_src;

  assign any_begin = begin_rdn_load | begin_dnn_load | begin_proc;
  assign busy      = (state != ST_IDLE);
  // begin_proc shares its instruction with the reg 0 write, so bypass the register.
  assign img_src   = (wr_en && (reg_sel == REG_IMG)) ? reg_databus : reg_img;

  always_comb begin
    phase_done = 1'b0;
    case (state)
      ST_RDN_LD:  phase_done = rdn_ld_done;
      ST_DNN_LD:  phase_done = dnn_ld_done;
      ST_RDN_RUN: phase_done = rdn_done;
      ST_DNN_RUN: phase_done = dnn_done;
      default:    phase_done = 1'b0;
    endcase
  end

  assign abort = wd_timeout && !phase_done;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (begin_proc) begin
          if (rdn_loaded && dnn_loaded) state_nx = ST_RDN_RUN;
        end else if (begin_rdn_load) begin
          state_nx = ST_RDN_LD;
        end else if (begin_dnn_load) begin
          state_nx = ST_DNN_LD;
        end
      end
      ST_RDN_LD, ST_DNN_LD, ST_DNN_RUN: begin
        if (phase_done || abort) state_nx = ST_IDLE;
      end
      ST_RDN_RUN: begin
        if (phase_done)  state_nx = ST_DNN_RUN;
        else if (abort)  state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign wd_clear  = (state_nx != state) || (state == ST_IDLE);
  assign wd_enable = (state != ST_IDLE);

  ctrl_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .timeout (wd_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_img <= '0;
      reg_rdn <= '0;
      reg_dnn <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_IMG: reg_img <= reg_databus;
        REG_RDN: reg_rdn <= reg_databus;
        REG_DNN: reg_dnn <= reg_databus;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rdn_loaded   <= 1'b0;
      dnn_loaded   <= 1'b0;
      rdn_ld_start <= 1'b0;
      dnn_ld_start <= 1'b0;
      rdn_start    <= 1'b0;
      dnn_start    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      ld_addr      <= '0;
      img_addr     <= '0;
    end else begin
      state        <= state_nx;
      rdn_ld_start <= 1'b0;
      dnn_ld_start <= 1'b0;
      rdn_start    <= 1'b0;
      dnn_start    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (begin_proc) begin
            if (rdn_loaded && dnn_loaded) begin
              img_addr  <= img_src;
              rdn_start <= 1'b1;
              err_code  <= ERR_NONE;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_NOT_LOADED;
            end
          end else if (begin_rdn_load) begin
            ld_addr      <= reg_rdn;
            rdn_ld_start <= 1'b1;
            rdn_loaded   <= 1'b0;
            err_code     <= ERR_NONE;
          end else if (begin_dnn_load) begin
            ld_addr      <= reg_dnn;
            dnn_ld_start <= 1'b1;
            dnn_loaded   <= 1'b0;
            err_code     <= ERR_NONE;
          end
        end
        ST_RDN_LD: begin
          if (phase_done) begin
            rdn_loaded <= 1'b1;
            done       <= 1'b1;
          end else if (abort) begin
            rdn_loaded <= 1'b0;
          end
        end
        ST_DNN_LD: begin
          if (phase_done) begin
            dnn_loaded <= 1'b1;
            done       <= 1'b1;
          end else if (abort) begin
            dnn_loaded <= 1'b0;
          end
        end
        ST_RDN_RUN: if (phase_done) dnn_start <= 1'b1;
        ST_DNN_RUN: if (phase_done) done <= 1'b1;
        default: ;
      endcase
      // A timeout outranks a busy-reject arriving in the same cycle.
      if (busy && abort) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (busy && any_begin) begin
        err      <= 1'b1;
        err_code <= ERR_BUSY;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: randomized command/strobe stimulus, transaction-level model, event scoreboard.
// Rev 1.0
`default_nettype none

module tb_ctrl_sequencer;

  localparam int AW = 28;
  localparam int TO = 16;
  localparam int CW = 5;
  localparam int K_RLS = 0, K_DLS = 1, K_RS = 2, K_DS = 3, K_DONE = 4, K_ERR = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    reg_sel = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] reg_databus = '0;
  logic          begin_rdn_load = 1'b0, begin_dnn_load = 1'b0, begin_proc = 1'b0;
  logic          rdn_ld_done = 1'b0, dnn_ld_done = 1'b0, rdn_done = 1'b0, dnn_done = 1'b0;
  logic          rdn_ld_start, dnn_ld_start, rdn_start, dnn_start, busy, done, err;
  logic [AW-1:0] ld_addr, img_addr;
  logic [1:0]    err_code;

  ctrl_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .reg_sel(reg_sel), .wr_en(wr_en), .reg_databus(reg_databus),
    .begin_rdn_load(begin_rdn_load), .begin_dnn_load(begin_dnn_load), .begin_proc(begin_proc),
    .rdn_ld_start(rdn_ld_start), .dnn_ld_start(dnn_ld_start), .ld_addr(ld_addr),
    .rdn_ld_done(rdn_ld_done), .dnn_ld_done(dnn_ld_done), .img_addr(img_addr),
    .rdn_start(rdn_start), .rdn_done(rdn_done), .dnn_start(dnn_start), .dnn_done(dnn_done),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    int            cyc;
    logic [AW-1:0] ld;
    logic [AW-1:0] img;
    logic [1:0]    code;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  // Reference model: what the host-visible state should be, tracked per transaction.
  logic [AW-1:0] regs [4];
  bit            rl, dl;
  logic [1:0]    code;
  logic [AW-1:0] exp_ld, exp_img;

  function automatic string kname(int k);
    case (k)
      K_RLS:   return "rdn_ld_start";
      K_DLS:   return "dnn_ld_start";
      K_RS:    return "rdn_start";
      K_DS:    return "dnn_start";
      K_DONE:  return "done";
      default: return "err";
    endcase
  endfunction

  function automatic void push(int kind, int c);
    ev_t e;
    e.kind = kind; e.cyc = c; e.ld = exp_ld; e.img = exp_img; e.code = code;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) regs[i] = '0;
    rl = 0; dl = 0; code = 2'b00; exp_ld = '0; exp_img = '0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic observe(int k);
    int idx = -1;
    ev_t e;
    foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == k) idx = i;
    tests++;
    if (idx < 0) begin
      fails++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d, expected none", kname(k), cyc);
    end else begin
      e = exp_q[idx];
      exp_q.delete(idx);
      if (e.cyc != cyc || e.ld !== ld_addr || e.img !== img_addr || e.code !== err_code) begin
        fails++;
        $display("FAIL %s: got cyc=%0d ld=%h img=%h code=%0d, expected cyc=%0d ld=%h img=%h code=%0d",
                 kname(k), cyc, ld_addr, img_addr, err_code, e.cyc, e.ld, e.img, e.code);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rdn_ld_start) observe(K_RLS);
      if (dnn_ld_start) observe(K_DLS);
      if (rdn_start)    observe(K_RS);
      if (dnn_start)    observe(K_DS);
      if (done)         observe(K_DONE);
      if (err)          observe(K_ERR);
    end
  end

  task automatic cycle_();
    if (wr_en && reg_sel != 2'd3) regs[reg_sel] = reg_databus;
    @(posedge clk);
    #1;
    begin_rdn_load = 0; begin_dnn_load = 0; begin_proc = 0; wr_en = 0;
    rdn_ld_done = 0; dnn_ld_done = 0; rdn_done = 0; dnn_done = 0;
  endtask

  task automatic set_strobe(int i);
    case (i)
      0: rdn_ld_done = 1;
      1: dnn_ld_done = 1;
      2: rdn_done = 1;
      default: dnn_done = 1;
    endcase
  endtask

  task automatic write_cfg(logic [1:0] sel, logic [AW-1:0] data);
    wr_en = 1; reg_sel = sel; reg_databus = data;
    cycle_();
  endtask

  // Issue a command from IDLE; which = 0 rdn load, 1 dnn load, 2 process, -1 none started.
  task automatic issue(bit br, bit bd, bit bp, bit wr, logic [1:0] sel, logic [AW-1:0] data,
                       output int which);
    int n = cyc;
    which = -1;
    begin_rdn_load = br; begin_dnn_load = bd; begin_proc = bp;
    wr_en = wr; reg_sel = sel; reg_databus = data;
    if ($urandom_range(0, 5) == 0) set_strobe($urandom_range(0, 3));
    if (bp) begin
      if (rl && dl) begin
        exp_img = (wr && sel == 2'd0) ? data : regs[0];
        code = 2'b00; push(K_RS, n + 1); which = 2;
      end else begin
        code = 2'b10; push(K_ERR, n + 1);
      end
    end else if (br) begin
      rl = 0; exp_ld = regs[1]; code = 2'b00; push(K_RLS, n + 1); which = 0;
    end else if (bd) begin
      dl = 0; exp_ld = regs[2]; code = 2'b00; push(K_DLS, n + 1); which = 1;
    end
    cycle_();
  endtask

  // Called on the entry cycle of a phase; dforce <0 random, 0..15 done offset, >=16 timeout.
  task automatic run_phase(int which, int dforce, output bit fin);
    int  d;
    bit  to;
    bit  last;
    fin = 0;
    d  = (dforce >= 0) ? dforce : (($urandom_range(0, 4) == 0) ? TO : $urandom_range(0, TO - 1));
    to = (d >= TO);
    for (int k = 0; k < TO; k++) begin
      fin  = !to && (k == d);
      last = to && (k == TO - 1);
      chk("busy_active", {31'd0, busy}, 32'd1);
      if (fin) set_strobe(which);
      if ($urandom_range(0, 7) == 0) set_strobe((which + 1 + $urandom_range(0, 2)) % 4);
      if (!last && $urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin_rdn_load = 1;
          1:       begin_dnn_load = 1;
          default: begin_proc = 1;
        endcase
        code = 2'b01; push(K_ERR, cyc + 1);
      end
      if (last) begin
        code = 2'b11;
        if (which == 0) rl = 0;
        if (which == 1) dl = 0;
        push(K_ERR, cyc + 1);
      end
      if (fin) begin
        if (which == 0) rl = 1;
        if (which == 1) dl = 1;
        push((which == 2) ? K_DS : K_DONE, cyc + 1);
      end
      if ($urandom_range(0, 4) == 0) begin
        wr_en = 1; reg_sel = 2'($urandom_range(0, 3)); reg_databus = AW'($urandom());
      end
      cycle_();
      if (fin || last) break;
    end
  endtask

  task automatic run_cmd(int which, int dforce);
    bit fin;
    if (which == 0 || which == 1) begin
      run_phase(which, dforce, fin);
    end else if (which == 2) begin
      run_phase(2, dforce, fin);
      if (fin) run_phase(3, dforce, fin);
    end
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int which;
    bit br, bd, bp, wr;
    logic [1:0] sel;
    logic [AW-1:0] data;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdn_ld_start", {31'd0, rdn_ld_start}, 32'd0);
    chk("rst_dnn_ld_start", {31'd0, dnn_ld_start}, 32'd0);
    chk("rst_rdn_start",    {31'd0, rdn_start},    32'd0);
    chk("rst_dnn_start",    {31'd0, dnn_start},    32'd0);
    chk("rst_done",         {31'd0, done},         32'd0);
    chk("rst_err",          {31'd0, err},          32'd0);
    chk("rst_busy",         {31'd0, busy},         32'd0);
    chk("rst_err_code",     {30'd0, err_code},     32'd0);
    chk("rst_ld_addr",      {4'd0, ld_addr},       32'd0);
    chk("rst_img_addr",     {4'd0, img_addr},      32'd0);
    rst_n = 1;
    cycle_();

    // RDN load from reg1 = 0x0001000, done ten cycles after entry.
    write_cfg(2'd1, 28'h0001000);
    issue(1, 0, 0, 0, 2'd0, '0, which);
    run_cmd(which, 10);

    // Process before both loads -> not-loaded reject.
    issue(0, 0, 1, 0, 2'd0, '0, which);
    chk("busy_after_reject", {31'd0, busy}, 32'd0);

    // DNN load times out, then a retry finishing on the very last allowed cycle.
    write_cfg(2'd2, 28'h0BEEF00);
    issue(0, 1, 0, 0, 2'd0, '0, which);
    run_cmd(which, TO);
    issue(0, 1, 0, 0, 2'd0, '0, which);
    run_cmd(which, TO - 1);

    // Both loaded: process with same-cycle image base write.
    issue(0, 0, 1, 1, 2'd0, 28'h0ABCDEF, which);
    run_cmd(which, 3);

    repeat (70) begin
      if ($urandom_range(0, 3) == 0) begin
        write_cfg(2'($urandom_range(0, 3)), AW'($urandom()));
      end else begin
        case ($urandom_range(0, 2))
          0:       begin br = 1; bd = 0; bp = 0; end
          1:       begin br = 0; bd = 1; bp = 0; end
          default: begin br = 0; bd = 0; bp = 1; end
        endcase
        if ($urandom_range(0, 4) == 0) begin
          br = br | $urandom_range(0, 1) == 1;
          bd = bd | $urandom_range(0, 1) == 1;
        end
        if (bp && !(rl && dl)) begin br = 0; bd = 0; end
        data = AW'($urandom());
        if (bp) begin
          wr = $urandom_range(0, 1) == 1; sel = 2'd0;
        end else begin
          wr = $urandom_range(0, 3) == 0; sel = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'd3;
        end
        issue(br, bd, bp, wr, sel, data, which);
        run_cmd(which, -1);
      end
    end

    // Reset in the middle of DNN_RUN.
    issue(1, 0, 0, 0, 2'd0, '0, which);
    run_cmd(which, 2);
    issue(0, 1, 0, 0, 2'd0, '0, which);
    run_cmd(which, 5);
    issue(0, 0, 1, 0, 2'd0, '0, which);
    run_phase(2, 0, br);
    cycle_();
    cycle_();
    chk("busy_dnn_run", {31'd0, busy}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy",     {31'd0, busy},     32'd0);
    chk("midrst_done",     {31'd0, done},     32'd0);
    chk("midrst_err",      {31'd0, err},      32'd0);
    chk("midrst_err_code", {30'd0, err_code}, 32'd0);
    chk("midrst_img_addr", {4'd0, img_addr},  32'd0);
    chk("midrst_ld_addr",  {4'd0, ld_addr},   32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    cycle_();
    issue(0, 0, 1, 0, 2'd0, '0, which);
    chk("busy_after_rst_reject", {31'd0, busy}, 32'd0);

    repeat (4) cycle_();
    foreach (exp_q[i]) begin
      tests++;
      fails++;
      $display("FAIL missing_%s: got no pulse, expected one at cycle %0d", kname(exp_q[i].kind), exp_q[i].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Control unit fed directly by the instruction decoder. Holds the three configuration address registers and sequences the datapath: RDN weight load, DNN weight load, and image processing (RDN pass, then DNN pass). Issues one-cycle start pulses with registered addresses, waits for done strobes, guards each phase with a watchdog, and reports busy/done/error back to the host side.

Parameters:
ADDR_W, 28, address/config register width (matches the decode data bus)
TIMEOUT_CYCLES, 1048576, max cycles in any active phase before abort
CNT_W, 21, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
reg_sel  in  2  config register index from decode
wr_en  in  1  config register write strobe
reg_databus  in  ADDR_W  config write data
begin_rdn_load  in  1  command: load RDN weights
begin_dnn_load  in  1  command: load DNN weights
begin_proc  in  1  command: process image
rdn_ld_start  out  1  one-cycle pulse: start RDN weight loader
dnn_ld_start  out  1  one-cycle pulse: start DNN weight loader
ld_addr  out  ADDR_W  weight base address for active load, registered
rdn_ld_done  in  1  RDN loader finished (pulse)
dnn_ld_done  in  1  DNN loader finished (pulse)
img_addr  out  ADDR_W  image base address for processing, registered
rdn_start  out  1  one-cycle pulse: start RDN pass
rdn_done  in  1  RDN pass finished (pulse)
dnn_start  out  1  one-cycle pulse: start DNN pass
dnn_done  in  1  DNN pass finished (pulse)
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse on successful completion of any command
err  out  1  one-cycle pulse on rejected command or timeout
err_code  out  2  00 none, 01 busy-reject, 10 not-loaded, 11 timeout; held until next err or command acceptance

Behaviour:
- Clock is clk; reset is asynchronous, active-low, on rst_n. Reset values: all outputs 0, state IDLE, config regs 0, loaded flags 0, watchdog 0.
- Config regs: reg 0 = image base, reg 1 = RDN weight base, reg 2 = DNN weight base. Write on wr_en at any time, including while busy; reg_sel=3 writes are ignored. New value is visible next cycle.
- Addresses are snapshotted into ld_addr/img_addr on command acceptance; later writes do not disturb a running phase.
- begin_proc arrives together with a reg 0 write (same instruction): img_addr takes reg_databus that cycle, not the stale reg 0.
- States: IDLE, RDN_LD, DNN_LD, RDN_RUN, DNN_RUN.
- IDLE + begin_rdn_load (cycle N): state RDN_LD, rdn_ld_start=1 and ld_addr=reg1 in cycle N+1. Same for DNN with reg2.
- IDLE + begin_proc: requires rdn_loaded and dnn_loaded, else err, err_code=10, stay IDLE. If accepted: RDN_RUN, rdn_start pulse at N+1.
- RDN_LD + rdn_ld_done: set rdn_loaded, done pulse next cycle, to IDLE. DNN_LD is symmetric.
- RDN_RUN + rdn_done: to DNN_RUN, dnn_start pulse next cycle. DNN_RUN + dnn_done: done pulse, to IDLE.
- Done strobes in a non-matching state are ignored.
- Starting a load clears that loaded flag at acceptance, so a partial reload never counts as loaded.
- Any begin_* while busy: dropped; err pulse, err_code=01; state unaffected.
- Simultaneous begin_* in IDLE: priority proc > rdn_load > dnn_load; lower ones dropped silently.
- Watchdog: clears on every state entry and increments each active cycle. At TIMEOUT_CYCLES-1 with no done: err, err_code=11, to IDLE, and that load's loaded flag is cleared. A done arriving in the same cycle wins over timeout.
- At most one start pulse per phase. Start and done in the same cycle as entry are legal: done is honoured.
- Mid-operation reset: immediate return to reset values and loaded flags cleared. Downstream must be reset by the same rst_n.

Decomposition:
- Shared package ctrl_pkg: state enum, err_code constants (ERR_NONE/BUSY/NOT_LOADED/TIMEOUT), REG_IMG/REG_RDN/REG_DNN index constants.
- One sub-module: ctrl_watchdog (clear, enable, timeout pulse; parameterised by TIMEOUT_CYCLES and CNT_W).

Test Plan:
- Write reg1=0x0001000, then begin_rdn_load -> rdn_ld_start pulse one cycle later with ld_addr=0x0001000; busy=1; rdn_ld_done after 10 cycles -> done pulse, busy=0.
- begin_proc with no loads -> err pulse, err_code=10, no rdn_start, state IDLE.
- Load both, then begin_proc with reg_databus=0x0ABCDEF -> img_addr=0x0ABCDEF, rdn_start; rdn_done -> dnn_start next cycle; dnn_done -> single done pulse.
- begin_dnn_load during RDN_LD -> err, err_code=01; RDN load still completes normally; writes to reg2 while busy leave ld_addr unchanged.
- TIMEOUT_CYCLES=16, DNN_LD with no done -> err, err_code=11 at cycle 16, dnn_loaded=0, IDLE. Repeat with dnn_ld_done on the last cycle -> done, no err.
- Assert rst_n low in DNN_RUN -> all outputs 0 immediately; a following begin_proc is rejected with err_code=10.
